wb_spi_master: RTL and testbench
================================

# wb_spi_master

Byte-wide Wishbone slave that turns register accesses from the CPLD's EPB-to-Wishbone bridge into SPI mode-0 transfers to an off-board serial device (configuration flash, sensors). It sits directly downstream of the bridge on the 5-bit-address, 8-bit-data Wishbone bus. It accepts the bridge's one-cycle `cyc`/`stb` strobe and returns a registered single-cycle ack with read data valid in the ack cycle.

## Interface
Parameters:
- `DIV_RESET`, default 7: reset value of the DIV register. SCLK half-period is DIV+1 clk cycles.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `wb_cyc_i`, `wb_stb_i`  in  1 each  Wishbone request. Both are high together for exactly one cycle per access.
- `wb_we_i`  in  1  1 = write.
- `wb_sel_i`  in  1  byte select; writes take effect only when it is 1.
- `wb_adr_i`  in  5  register address.
- `wb_dat_i`  in  8  write data.
- `wb_dat_o`  out  8  read data, registered.
- `wb_ack_o`  out  1  access acknowledge, single-cycle pulse.
- `spi_sclk`  out  1  SPI clock, idles low.
- `spi_mosi`  out  1  serial data out.
- `spi_miso`  in  1  serial data in.
- `spi_cs_n`  out  1  chip select, active low.
- `irq`  out  1  transfer-done interrupt. Present only with `WB_SPI_IRQ_EN`.

## Operation
- Request = `wb_cyc_i & wb_stb_i & !wb_ack_o`.
  - On the request cycle the block decodes the address, performs the write or read side effect, and loads `wb_dat_o`.
  - `wb_ack_o` is high on the next cycle for one cycle.
- Register map:
  - 0x00 DATA. Write: if idle, latch the byte and DIV, and start a transfer. If busy, the write is ignored and OVR is set. Read: last received byte; clears DONE.
  - 0x01 STATUS, read-only except W1C bits. Bit0 BUSY, bit1 DONE (sticky), bit2 OVR (W1C). Bit3 IE when `WB_SPI_IRQ_EN`, else reads 0. Bits 7:4 read 0.
  - 0x02 CTRL, R/W. Bit0 CS: `spi_cs_n` = !CS. Bit1 LSBF: 1 = LSB first. Other bits read 0.
  - 0x03 DIV, R/W, 8 bits.
  - 0x04–0x1F: read 0x00, writes ignored, still acked.
- Shift engine FSM:
  - IDLE → LOAD on DATA write.
  - LOAD drives the first bit on `spi_mosi`, then → SHIFT.
  - SHIFT alternates phases, each DIV+1 cycles long:
    - Rising edge: sample `spi_miso` into the shift register.
    - Falling edge: present the next bit.
  - After the 8th falling edge: → IDLE, BUSY clears, DONE sets, received byte goes to RXDATA.
- Arithmetic: half-period counter is 8 bits and counts 0..DIV. Bit counter is 3 bits and wraps after 8.
- Changing DIV while busy does not affect the current transfer. Changing CTRL.CS while busy takes effect immediately; software must not do this.

## Timing
- Reset values:
  - `wb_ack_o` = 0, `wb_dat_o` = 0x00.
  - `spi_sclk` = 0, `spi_mosi` = 0, `spi_cs_n` = 1, `irq` = 0.
  - DIV = `DIV_RESET`; CTRL, STATUS and RXDATA = 0.
- Reset mid-transfer aborts on the next edge: SCLK low, CS deasserted.
- Access latency: ack exactly 1 cycle after the request, for reads and writes. `wb_dat_o` is valid in the ack cycle and holds until the next request.
- Transfer timing, for a DATA write request at cycle T:
  - T+1: BUSY = 1 and `spi_mosi` = first bit.
  - Rising SCLK at T+1+(DIV+1); edges every DIV+1 cycles after that.
  - Cycle T+1+16·(DIV+1): final falling edge, BUSY = 0, DONE = 1.
- A STATUS read on the request cycle reflects flags as of that cycle.
- Simultaneous events:
  - DONE set and DATA read in the same cycle: set wins.
  - OVR set and W1C in the same cycle: set wins.
  - A DATA write in the cycle BUSY falls is accepted and starts a new transfer.

## Configuration
- `WB_SPI_IRQ_EN` defined:
  - Port `irq` and STATUS bit3 IE (R/W) exist.
  - `irq` = registered (DONE & IE), asserted the cycle after DONE sets and cleared the cycle after DONE clears.
- Undefined: no `irq` port, bit3 reads 0 and ignores writes. Behaviour is otherwise identical.

## Test plan
- Reset, then read 0x03 → ack 1 cycle later, data 0x07. `spi_cs_n` = 1, `spi_sclk` = 0.
- Write CTRL = 0x01, DIV = 0x01, DATA = 0xA5 with MISO driving 0x3C MSB first:
  - MOSI shows 1,0,1,0,0,1,0,1 on rising edges; edges 2 cycles apart; BUSY for 32 cycles.
  - Then STATUS = 0x02 and a DATA read returns 0x3C with DONE cleared.
- With LSBF = 1, send 0x01 → MOSI high only for the first bit. Received bits are assembled LSB first.
- Write DATA while busy → current transfer is unaffected and STATUS bit2 = 1. Writing 0x04 to STATUS clears it.
- Assert reset at the 4th SCLK edge → next cycle SCLK = 0, CS_N = 1, BUSY = 0, no ack pending.
- With `WB_SPI_IRQ_EN`: IE = 1, transfer completes → `irq` rises 1 cycle after DONE. A DATA read drops `irq` 1 cycle after DONE clears. Without the macro, the `irq` port is absent and bit3 reads 0.

Source files
------------

// File: rtl/wb_spi_master_if.sv
// Wishbone byte bus between the EPB bridge and the SPI master.
interface wb_spi_master_if;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic       wb_sel_i;
  logic [4:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_spi_master.sv
// Wishbone-to-SPI mode-0 byte master; optional irq with WB_SPI_IRQ_EN.
module wb_spi_master #(
  parameter logic [7:0] DIV_RESET = 8'd7
) (
  input  logic clk,
  input  logic reset,
  wb_spi_master_if.slave wb,
  output logic spi_sclk,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic spi_cs_n
`ifdef WB_SPI_IRQ_EN
  ,
  output logic irq
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t     state;
  logic [7:0] div;
  logic [7:0] xdiv;
  logic [7:0] cnt;
  logic [7:0] shreg;
  logic [7:0] rxdata;
  logic [7:0] rd;
  logic [2:0] bitcnt;
  logic [1:0] ctrl;
  logic       xlsbf;
  logic       busy;
  logic       done;
  logic       ovr;
  logic       ie;
  logic       req;
  logic       wr;
  logic       a_data;
  logic       a_stat;
  logic       a_ctrl;
  logic       a_div;

  assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr     = req & wb.wb_we_i & wb.wb_sel_i;
  assign a_data = wb.wb_adr_i == 5'h00;
  assign a_stat = wb.wb_adr_i == 5'h01;
  assign a_ctrl = wb.wb_adr_i == 5'h02;
  assign a_div  = wb.wb_adr_i == 5'h03;
  assign spi_cs_n = ~ctrl[0];

`ifndef WB_SPI_IRQ_EN
  assign ie = 1'b0;
`endif

  always_comb begin
    rd = 8'h00;
    unique case (1'b1)
      a_data:  rd = rxdata;
      a_stat:  rd = {4'h0, ie, ovr, done, busy};
      a_ctrl:  rd = {6'h00, ctrl};
      a_div:   rd = div;
      default: rd = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= 8'h00;
      div         <= DIV_RESET;
      xdiv        <= DIV_RESET;
      cnt         <= 8'h00;
      shreg       <= 8'h00;
      rxdata      <= 8'h00;
      bitcnt      <= 3'd0;
      ctrl        <= 2'b00;
      xlsbf       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovr         <= 1'b0;
      spi_sclk    <= 1'b0;
      spi_mosi    <= 1'b0;
    end else begin
      wb.wb_ack_o <= req;
      if (req) wb.wb_dat_o <= rd;
      // clears first so same-cycle sets below win
      if (req & ~wb.wb_we_i & a_data) done <= 1'b0;
      if (wr & a_stat & wb.wb_dat_i[2]) ovr <= 1'b0;
      if (wr & a_ctrl) ctrl <= wb.wb_dat_i[1:0];
      if (wr & a_div) div <= wb.wb_dat_i;
      if (wr & a_data & busy) ovr <= 1'b1;
      unique case (state)
        IDLE: begin
          if (wr & a_data) begin
            state    <= LOAD;
            busy     <= 1'b1;
            xdiv     <= div;
            xlsbf    <= ctrl[1];
            cnt      <= 8'h00;
            bitcnt   <= 3'd0;
            shreg    <= wb.wb_dat_i;
            spi_mosi <= ctrl[1] ? wb.wb_dat_i[0]
                                : wb.wb_dat_i[7];
          end
        end
        LOAD, SHIFT: begin
          state <= SHIFT;
          if (cnt != xdiv) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt <= 8'h00;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              shreg <= xlsbf ? {spi_miso, shreg[7:1]}
                             : {shreg[6:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              bitcnt   <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                state  <= IDLE;
                busy   <= 1'b0;
                done   <= 1'b1;
                rxdata <= shreg;
              end else begin
                spi_mosi <= xlsbf ? shreg[0] : shreg[7];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_SPI_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr & a_stat) ie <= wb.wb_dat_i[3];
      irq <= done & ie;
    end
  end
`endif

endmodule

// File: tb/tb_wb_spi_master.sv
// Directed bench for wb_spi_master with a read/MOSI scoreboard.
module tb_wb_spi_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_miso = 1'b0;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_cs_n;
`ifdef WB_SPI_IRQ_EN
  logic irq;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rdq[$];
  logic       mosiq[$];

  wb_spi_master_if bus();

  wb_spi_master #(.DIV_RESET(8'd7)) dut (
    .clk(clk),
    .reset(reset),
    .wb(bus.slave),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
`ifdef WB_SPI_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic bus_req(input logic we,
                         input logic sel,
                         input logic [4:0] adr,
                         input logic [7:0] dat);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
  endtask

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] adr,
                          input logic [7:0] dat,
                          input logic sel = 1'b1);
    @(negedge clk);
    bus_req(1'b1, sel, adr, dat);
    @(negedge clk);
    bus_idle();
    check("wr_ack", 32'(bus.wb_ack_o), 32'd1);
  endtask

  task automatic wb_read(input string tag,
                         input logic [4:0] adr,
                         input logic [7:0] exp);
    logic [7:0] e;
    rdq.push_back(exp);
    @(negedge clk);
    bus_req(1'b0, 1'b1, adr, 8'h00);
    @(negedge clk);
    bus_idle();
    check("rd_ack", 32'(bus.wb_ack_o), 32'd1);
    e = rdq.pop_front();
    check(tag, 32'(bus.wb_dat_o), 32'(e));
    @(negedge clk);
    check("ack_pulse", 32'(bus.wb_ack_o), 32'd0);
    check("dat_hold", 32'(bus.wb_dat_o), 32'(e));
  endtask

  // Runs one DATA write and follows SCLK; rst_at aborts at that edge.
  task automatic transfer(input logic [7:0] tx,
                          input logic [7:0] rx,
                          input bit lsbf,
                          input int d,
                          input int ovr_at,
                          input int rst_at);
    int n;
    int edges;
    int bi;
    logic prev;
    for (int i = 0; i < 8; i++)
      mosiq.push_back(lsbf ? tx[i] : tx[7-i]);
    bi = 0;
    spi_miso = lsbf ? rx[0] : rx[7];
    @(negedge clk);
    bus_req(1'b1, 1'b1, 5'h00, tx);
    @(negedge clk);
    bus_idle();
    check("data_wr_ack", 32'(bus.wb_ack_o), 32'd1);
    check("first_mosi", 32'(spi_mosi),
          32'(lsbf ? tx[0] : tx[7]));
    check("sclk_low_t1", 32'(spi_sclk), 32'd0);
    n = 1;
    edges = 0;
    prev = spi_sclk;
    while (edges < 16 && n < 2000) begin
      @(negedge clk);
      n++;
      if (spi_sclk !== prev) begin
        edges++;
        check("edge_time", n, 1 + edges * (d + 1));
        if (spi_sclk) begin
          check("mosi_bit", 32'(spi_mosi),
                32'(mosiq.pop_front()));
        end else begin
          bi++;
          if (bi < 8) spi_miso = lsbf ? rx[bi] : rx[7-bi];
        end
        prev = spi_sclk;
      end
      if (ovr_at != 0 && n == ovr_at)
        bus_req(1'b1, 1'b1, 5'h00, 8'hFF);
      if (ovr_at != 0 && n == ovr_at + 1) begin
        bus_idle();
        check("ovr_ack", 32'(bus.wb_ack_o), 32'd1);
      end
      if (rst_at != 0 && edges == rst_at) begin
        reset = 1'b1;
        bus_req(1'b0, 1'b1, 5'h01, 8'h00);
        @(negedge clk);
        bus_idle();
        reset = 1'b0;
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_no_ack", 32'(bus.wb_ack_o), 32'd0);
        mosiq.delete();
        return;
      end
    end
    check("xfer_edges", edges, 16);
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 1'b0;
    bus.wb_adr_i = 5'h00;
    bus.wb_dat_i = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rst_dat", 32'(bus.wb_dat_o), 32'h00);
    check("rst_sclk0", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_csn", 32'(spi_cs_n), 32'd1);
`ifdef WB_SPI_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif
    wb_read("div_rst", 5'h03, 8'h07);
    wb_read("stat_rst", 5'h01, 8'h00);
    wb_read("ctrl_rst", 5'h02, 8'h00);
    wb_read("data_rst", 5'h00, 8'h00);

    wb_write(5'h02, 8'hFF);
    wb_read("ctrl_mask", 5'h02, 8'h03);
    wb_write(5'h02, 8'h01);
    check("cs_on", 32'(spi_cs_n), 32'd0);
    wb_write(5'h03, 8'h01);
    wb_read("div_wr", 5'h03, 8'h01);
    wb_write(5'h03, 8'h44, 1'b0);
    wb_read("div_nosel", 5'h03, 8'h01);
    wb_write(5'h04, 8'h55);
    wb_read("unmapped04", 5'h04, 8'h00);
    wb_read("unmapped1f", 5'h1F, 8'h00);

    transfer(8'hA5, 8'h3C, 1'b0, 1, 0, 0);
    wb_read("stat_done", 5'h01, 8'h02);
    wb_read("rx_msb", 5'h00, 8'h3C);
    wb_read("stat_clr", 5'h01, 8'h00);

    wb_write(5'h02, 8'h03);
    transfer(8'h01, 8'h96, 1'b1, 1, 0, 0);
    wb_read("rx_lsb", 5'h00, 8'h96);

    wb_write(5'h02, 8'h01);
    wb_write(5'h03, 8'h00);
    transfer(8'hC3, 8'h5A, 1'b0, 0, 0, 0);
    wb_read("rx_div0", 5'h00, 8'h5A);

    wb_write(5'h03, 8'h02);
    transfer(8'h5A, 8'hC3, 1'b0, 2, 10, 0);
    wb_read("stat_ovr", 5'h01, 8'h06);
    wb_read("rx_ovr", 5'h00, 8'hC3);
    wb_write(5'h01, 8'h04);
    wb_read("ovr_w1c", 5'h01, 8'h00);

    transfer(8'hFF, 8'h00, 1'b0, 2, 0, 4);
    wb_read("stat_abort", 5'h01, 8'h00);
    wb_read("div_abort", 5'h03, 8'h07);
    wb_read("ctrl_abort", 5'h02, 8'h00);

`ifdef WB_SPI_IRQ_EN
    wb_write(5'h02, 8'h01);
    wb_write(5'h03, 8'h01);
    wb_write(5'h01, 8'h08);
    wb_read("ie_rd", 5'h01, 8'h08);
    transfer(8'h81, 8'h7E, 1'b0, 1, 0, 0);
    check("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(irq), 32'd1);
    @(negedge clk);
    bus_req(1'b0, 1'b1, 5'h00, 8'h00);
    @(negedge clk);
    bus_idle();
    check("irq_rx", 32'(bus.wb_dat_o), 32'h7E);
    check("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_fall", 32'(irq), 32'd0);
`else
    wb_write(5'h01, 8'h08);
    wb_read("ie_absent", 5'h01, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
